// File: rtl/ddr3_page_engine.sv
// rtl/ddr3_page_engine.sv - page-sized DDR3 MIG burst engine between pipe FIFO and decoder FIFO
//
// Purpose:
//   Runs whole write pages (pipe FIFO -> MIG) while i_cmd_pagewrite is high and
//   whole read pages (MIG -> decoder FIFO) while i_cmd_pageread is high. Each
//   page is PAGE_BURSTS bursts of BEATS beats. Write and read address pointers
//   are independent; only i_sdramctrl_reset rewinds them.
//
// Ports:
//   i_sdramclk, i_sdramctrl_reset     clock, synchronous active-high reset
//   i_cmd_pagewrite, i_cmd_pageread   level page requests, sampled only when idle
//   i_fifo_dout/i_fifo_empty          pipe FIFO head word (FWFT) and empty flag
//   o_fifo_rd_en                      pipe FIFO pop, only on a write beat transfer
//   i_dec_prog_full                   decoder FIFO cannot take another page
//   o_dec_din/o_dec_wr_en             decoder FIFO push, one cycle after read data
//   i_app_rdy/i_app_wdf_rdy           MIG command / write-data accept
//   i_app_rd_data/_valid              MIG read return
//   o_app_en/o_app_cmd/o_app_addr     MIG command (000 write, 001 read)
//   o_app_wdf_wren/_data/_end         MIG write data, _end on the last beat of a burst
//   o_page_done                       one-cycle pulse at the end of each page
//   o_busy                            engine not idle

module ddr3_page_engine #(
  parameter int ADDR_WIDTH  = 28,
  parameter int DATA_WIDTH  = 128,
  parameter int BEATS       = 2,
  parameter int ADDR_INC    = 8,
  parameter int PAGE_BURSTS = 64,
  parameter int ADDR_LIMIT  = 2**27
) (
  input  logic                  i_sdramclk,
  input  logic                  i_sdramctrl_reset,
  input  logic                  i_cmd_pagewrite,
  input  logic                  i_cmd_pageread,
  input  logic [DATA_WIDTH-1:0] i_fifo_dout,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_rd_en,
  input  logic                  i_dec_prog_full,
  output logic [DATA_WIDTH-1:0] o_dec_din,
  output logic                  o_dec_wr_en,
  input  logic                  i_app_rdy,
  input  logic                  i_app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0] i_app_rd_data,
  input  logic                  i_app_rd_data_valid,
  output logic                  o_app_en,
  output logic [2:0]            o_app_cmd,
  output logic [ADDR_WIDTH-1:0] o_app_addr,
  output logic                  o_app_wdf_wren,
  output logic [DATA_WIDTH-1:0] o_app_wdf_data,
  output logic                  o_app_wdf_end,
  output logic                  o_page_done,
  output logic                  o_busy
);

  localparam int BURST_W  = $clog2(PAGE_BURSTS + 1);
  localparam int BEAT_W   = $clog2(BEATS + 1);
  localparam int RX_TOTAL = PAGE_BURSTS * BEATS;
  localparam int RX_W     = $clog2(RX_TOTAL + 1);

  localparam logic [BURST_W-1:0]  LAST_BURST = BURST_W'(PAGE_BURSTS - 1);
  localparam logic [BEAT_W-1:0]   LAST_BEAT  = BEAT_W'(BEATS - 1);
  localparam logic [RX_W-1:0]     RX_DONE    = RX_W'(RX_TOTAL);
  localparam logic [ADDR_WIDTH:0] INC        = (ADDR_WIDTH + 1)'(ADDR_INC);
  localparam logic [ADDR_WIDTH:0] LIMIT      = (ADDR_WIDTH + 1)'(ADDR_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_DATA,
    S_WR_CMD,
    S_RD_CMD,
    S_RD_DRAIN
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [BURST_W-1:0]    r_burst_cnt;
  logic [BEAT_W-1:0]     r_beat_cnt;
  logic [RX_W-1:0]       r_rx_cnt;
  logic                  r_page_done;
  logic                  r_dec_wr_en;
  logic [DATA_WIDTH-1:0] r_dec_din;

  logic                  w_wr_data;
  logic                  w_wr_cmd;
  logic                  w_rd_cmd;
  logic                  w_beat_xfer;
  logic                  w_cmd_acc;
  logic [ADDR_WIDTH:0]   w_wr_sum;
  logic [ADDR_WIDTH:0]   w_rd_sum;
  logic [ADDR_WIDTH-1:0] w_wr_next;
  logic [ADDR_WIDTH-1:0] w_rd_next;
  logic [RX_W-1:0]       w_rx_next;

  assign w_wr_data = (r_state == S_WR_DATA);
  assign w_wr_cmd  = (r_state == S_WR_CMD);
  assign w_rd_cmd  = (r_state == S_RD_CMD);

  // Data and command phases live in different states, so app_en and
  // app_wdf_wren can never be high together.
  assign o_app_wdf_wren = w_wr_data && !i_fifo_empty;
  assign w_beat_xfer    = o_app_wdf_wren && i_app_wdf_rdy;
  assign o_fifo_rd_en   = w_beat_xfer;
  assign o_app_wdf_data = w_wr_data ? i_fifo_dout : '0;
  assign o_app_wdf_end  = w_wr_data && (r_beat_cnt == LAST_BEAT);

  // Address comes straight from the pointer, which only moves on acceptance,
  // so a pending command stays stable until the MIG takes it.
  assign o_app_en   = w_wr_cmd || (w_rd_cmd && !i_dec_prog_full);
  assign o_app_cmd  = w_rd_cmd ? 3'b001 : 3'b000;
  assign o_app_addr = w_wr_cmd ? r_wr_ptr : (w_rd_cmd ? r_rd_ptr : '0);
  assign w_cmd_acc  = o_app_en && i_app_rdy;

  // Pointer sums carry one spare bit so the limit compare cannot overflow.
  assign w_wr_sum  = {1'b0, r_wr_ptr} + INC;
  assign w_rd_sum  = {1'b0, r_rd_ptr} + INC;
  assign w_wr_next = (w_wr_sum == LIMIT) ? '0 : w_wr_sum[ADDR_WIDTH-1:0];
  assign w_rd_next = (w_rd_sum == LIMIT) ? '0 : w_rd_sum[ADDR_WIDTH-1:0];

  // Read beats are counted in every state; drain completion looks at the
  // post-increment count so the final push and page_done share a cycle.
  assign w_rx_next = r_rx_cnt + RX_W'(i_app_rd_data_valid);

  assign o_busy      = (r_state != S_IDLE);
  assign o_page_done = r_page_done;
  assign o_dec_wr_en = r_dec_wr_en;
  assign o_dec_din   = r_dec_din;

  always_ff @(posedge i_sdramclk) begin
    if (i_sdramctrl_reset) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_burst_cnt <= '0;
      r_beat_cnt  <= '0;
      r_rx_cnt    <= '0;
      r_page_done <= 1'b0;
      r_dec_wr_en <= 1'b0;
      r_dec_din   <= '0;
    end else begin
      r_page_done <= 1'b0;
      r_dec_wr_en <= i_app_rd_data_valid;
      if (i_app_rd_data_valid) begin
        r_dec_din <= i_app_rd_data;
      end
      r_rx_cnt <= w_rx_next;

      case (r_state)
        S_IDLE: begin
          if (i_cmd_pagewrite) begin
            r_state     <= S_WR_DATA;
            r_burst_cnt <= '0;
            r_beat_cnt  <= '0;
          end else if (i_cmd_pageread) begin
            r_state     <= S_RD_CMD;
            r_burst_cnt <= '0;
          end
        end

        S_WR_DATA: begin
          if (w_beat_xfer) begin
            if (r_beat_cnt == LAST_BEAT) begin
              r_beat_cnt <= '0;
              r_state    <= S_WR_CMD;
            end else begin
              r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
            end
          end
        end

        S_WR_CMD: begin
          if (i_app_rdy) begin
            r_wr_ptr    <= w_wr_next;
            r_burst_cnt <= r_burst_cnt + BURST_W'(1);
            if (r_burst_cnt == LAST_BURST) begin
              r_state     <= S_IDLE;
              r_page_done <= 1'b1;
            end else begin
              r_state <= S_WR_DATA;
            end
          end
        end

        S_RD_CMD: begin
          if (w_cmd_acc) begin
            r_rd_ptr    <= w_rd_next;
            r_burst_cnt <= r_burst_cnt + BURST_W'(1);
            if (r_burst_cnt == LAST_BURST) begin
              r_state <= S_RD_DRAIN;
            end
          end
        end

        S_RD_DRAIN: begin
          if (w_rx_next == RX_DONE) begin
            r_state     <= S_IDLE;
            r_page_done <= 1'b1;
            r_rx_cnt    <= '0;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_page_engine.sv
// tb/tb_ddr3_page_engine.sv - randomized self-checking bench for ddr3_page_engine

module tb_ddr3_page_engine;

  localparam int AW    = 28;
  localparam int DW    = 32;
  localparam int BEATS = 2;
  localparam int INC   = 8;
  localparam int PB    = 4;
  localparam int LIM   = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_w, cmd_r;
  logic [DW-1:0] fifo_dout;
  logic          fifo_empty, fifo_rd_en;
  logic          prog_full;
  logic [DW-1:0] dec_din;
  logic          dec_wr_en;
  logic          app_rdy, wdf_rdy;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          app_en;
  logic [2:0]    app_cmd;
  logic [AW-1:0] app_addr;
  logic          wdf_wren;
  logic [DW-1:0] wdf_data;
  logic          wdf_end, page_done, busy;

  always #5 clk = ~clk;

  ddr3_page_engine #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEATS(BEATS),
    .ADDR_INC(INC), .PAGE_BURSTS(PB), .ADDR_LIMIT(LIM)
  ) dut (
    .i_sdramclk(clk), .i_sdramctrl_reset(rst),
    .i_cmd_pagewrite(cmd_w), .i_cmd_pageread(cmd_r),
    .i_fifo_dout(fifo_dout), .i_fifo_empty(fifo_empty), .o_fifo_rd_en(fifo_rd_en),
    .i_dec_prog_full(prog_full), .o_dec_din(dec_din), .o_dec_wr_en(dec_wr_en),
    .i_app_rdy(app_rdy), .i_app_wdf_rdy(wdf_rdy),
    .i_app_rd_data(rd_data), .i_app_rd_data_valid(rd_valid),
    .o_app_en(app_en), .o_app_cmd(app_cmd), .o_app_addr(app_addr),
    .o_app_wdf_wren(wdf_wren), .o_app_wdf_data(wdf_data), .o_app_wdf_end(wdf_end),
    .o_page_done(page_done), .o_busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: pipe FIFO contents, log of every word pushed since reset,
  // and running counts of beats and commands from which addresses follow.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] pushed[$];
  int            wbeats, wcmds, rcmds, pend_beats, rx_page, pd_count, n_dec;
  bit            exp_pd, rx_exp_v, prev_hold;
  logic [DW-1:0] rx_exp;
  logic [AW-1:0] prev_addr;
  logic [2:0]    prev_cmd;
  int            p_rdy, p_wdf, p_stall, p_rv;
  bit            force_wdf_low, force_pf;

  task automatic model_clear();
    fifo_q.delete();
    pushed.delete();
    wbeats = 0; wcmds = 0; rcmds = 0; pend_beats = 0; rx_page = 0;
    exp_pd = 0; prev_hold = 0;
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] w;
      w = $urandom;
      fifo_q.push_back(w);
      pushed.push_back(w);
    end
  endtask

  task automatic monitor(input bit was_reset);
    bit xfer;
    if (was_reset) begin
      check_eq("rst_app_en", app_en, 0);
      check_eq("rst_app_cmd", app_cmd, 0);
      check_eq("rst_app_addr", app_addr, 0);
      check_eq("rst_wdf_wren", wdf_wren, 0);
      check_eq("rst_wdf_data", wdf_data, 0);
      check_eq("rst_wdf_end", wdf_end, 0);
      check_eq("rst_fifo_rd_en", fifo_rd_en, 0);
      check_eq("rst_dec_wr_en", dec_wr_en, 0);
      check_eq("rst_dec_din", dec_din, 0);
      check_eq("rst_page_done", page_done, 0);
      check_eq("rst_busy", busy, 0);
      rx_exp_v = rd_valid;
      rx_exp   = rd_data;
      return;
    end

    check_eq("dec_wr_en", dec_wr_en, rx_exp_v);
    if (rx_exp_v) check_eq("dec_din", dec_din, rx_exp);
    if (dec_wr_en) n_dec++;
    check_eq("page_done", page_done, exp_pd);
    if (page_done) pd_count++;
    exp_pd = 0;

    check_eq("en_wren_excl", app_en && wdf_wren, 0);
    if (prev_hold) begin
      check_eq("hold_en", app_en, 1);
      check_eq("hold_addr", app_addr, prev_addr);
      check_eq("hold_cmd", app_cmd, prev_cmd);
    end
    prev_hold = app_en && !app_rdy;
    prev_addr = app_addr;
    prev_cmd  = app_cmd;

    if (prog_full) check_eq("pf_blocks_read", app_en && (app_cmd == 3'b001), 0);
    if (wdf_wren) check_eq("wren_needs_data", fifo_empty, 0);

    xfer = wdf_wren && wdf_rdy;
    check_eq("fifo_rd_en", fifo_rd_en, xfer);
    if (xfer) begin
      check_eq("wdf_data", wdf_data, (wbeats < pushed.size()) ? pushed[wbeats] : 'x);
      check_eq("wdf_end", wdf_end, (wbeats % BEATS) == BEATS - 1);
      wbeats++;
    end
    if (fifo_rd_en && fifo_q.size() > 0) void'(fifo_q.pop_front());

    if (app_en && app_rdy) begin
      if (app_cmd == 3'b000) begin
        check_eq("wr_addr", app_addr, (wcmds * INC) % LIM);
        check_eq("wr_data_before_cmd", wbeats, (wcmds + 1) * BEATS);
        wcmds++;
        if (wcmds % PB == 0) exp_pd = 1;
      end else begin
        check_eq("rd_cmd_code", app_cmd, 3'b001);
        check_eq("rd_addr", app_addr, (rcmds * INC) % LIM);
        rcmds++;
        pend_beats += BEATS;
      end
    end

    rx_exp_v = rd_valid;
    rx_exp   = rd_data;
    if (rd_valid) begin
      pend_beats--;
      rx_page++;
      if (rx_page == PB * BEATS) begin
        exp_pd  = 1;
        rx_page = 0;
      end
    end
  endtask

  task automatic cycle();
    bit was_reset;
    @(posedge clk);
    was_reset = rst;
    #1;
    app_rdy    = ($urandom_range(99) < p_rdy);
    wdf_rdy    = !force_wdf_low && ($urandom_range(99) < p_wdf);
    fifo_empty = (fifo_q.size() == 0) || ($urandom_range(99) < p_stall);
    fifo_dout  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    prog_full  = force_pf;
    rd_valid   = (pend_beats > 0) && ($urandom_range(99) < p_rv);
    rd_data    = $urandom;
    @(negedge clk);
    monitor(was_reset);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_clear();
    cycle();
    rst = 1'b0;
  endtask

  task automatic start_page(input bit w, input bit r, input bit keep_r);
    cmd_w = w;
    cmd_r = r;
    for (int i = 0; i < 20 && !busy; i++) cycle();
    check_eq("start_busy", busy, 1);
    cmd_w = 1'b0;
    if (!keep_r) cmd_r = 1'b0;
  endtask

  task automatic wait_pd(input int target);
    for (int i = 0; i < 3000 && pd_count < target; i++) cycle();
    check_eq("page_done_count", pd_count, target);
  endtask

  initial begin
    rst = 1'b1; cmd_w = 0; cmd_r = 0;
    fifo_dout = '0; fifo_empty = 1; prog_full = 0; app_rdy = 0; wdf_rdy = 0;
    rd_data = '0; rd_valid = 0;
    pd_count = 0; n_dec = 0; rx_exp_v = 0; rx_exp = '0;
    force_wdf_low = 0; force_pf = 0;
    p_rdy = 100; p_wdf = 100; p_stall = 0; p_rv = 100;
    model_clear();

    do_reset();
    do_reset();
    cycle();

    // Single write page, everything ready, FIFO preloaded.
    push_words(8);
    start_page(1, 0, 0);
    wait_pd(1);
    repeat (3) cycle();
    check_eq("t1_beats", wbeats, 8);
    check_eq("t1_cmds", wcmds, 4);
    check_eq("t1_single_pd", pd_count, 1);
    check_eq("t1_idle", busy, 0);

    // Second write page with stalls; addresses must wrap back to 0.
    p_rdy = 50; p_wdf = 60; p_stall = 40;
    push_words(8);
    start_page(1, 0, 0);
    cycle();
    force_wdf_low = 1;
    repeat (5) cycle();
    force_wdf_low = 0;
    wait_pd(2);
    check_eq("t2_beats", wbeats, 16);
    check_eq("t2_cmds", wcmds, 8);
    check_eq("t2_fifo_drained", fifo_q.size(), 0);

    // Read page held off by decoder back-pressure.
    p_rv = 70;
    force_pf = 1;
    start_page(0, 1, 0);
    repeat (10) cycle();
    check_eq("t3_no_read_while_full", rcmds, 0);
    force_pf = 0;
    wait_pd(3);
    cycle();
    check_eq("t3_rd_cmds", rcmds, 4);
    check_eq("t3_dec_beats", n_dec, 8);
    check_eq("t3_pend", pend_beats, 0);

    // Both requests at once: write page first, read page honoured afterwards.
    push_words(8);
    start_page(1, 1, 1);
    wait_pd(4);
    check_eq("t4_write_first_w", wcmds, 12);
    check_eq("t4_write_first_r", rcmds, 4);
    for (int i = 0; i < 20 && !busy; i++) cycle();
    check_eq("t4_read_started", busy, 1);
    cmd_r = 1'b0;
    wait_pd(5);
    cycle();
    check_eq("t4_rd_cmds", rcmds, 8);
    check_eq("t4_dec_beats", n_dec, 16);

    // Reset mid-page: abandoned without page_done, pointers rewound.
    p_rdy = 100; p_wdf = 100; p_stall = 0;
    push_words(8);
    start_page(1, 0, 0);
    cycle();
    do_reset();
    repeat (4) cycle();
    check_eq("t6_no_pd", pd_count, 5);
    check_eq("t6_idle", busy, 0);
    push_words(8);
    start_page(1, 0, 0);
    wait_pd(6);
    check_eq("t6_cmds_after_rst", wcmds, 4);

    // Random mix of pages and ready patterns.
    for (int k = 0; k < 6; k++) begin
      p_rdy = $urandom_range(30, 100);
      p_wdf = $urandom_range(30, 100);
      p_stall = $urandom_range(0, 50);
      p_rv = $urandom_range(30, 100);
      if ($urandom_range(1)) begin
        push_words(PB * BEATS);
        start_page(1, 0, 0);
      end else begin
        start_page(0, 1, 0);
      end
      wait_pd(7 + k);
    end
    repeat (5) cycle();
    check_eq("final_idle", busy, 0);
    check_eq("final_pend", pend_beats, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
